// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants: bus widths, reset values, FSM states, queue entry.
package if_stage_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int FifoDepth   = 2;

    localparam logic [InstBus-1:0]     ZeroWord    = 32'h0000_0000;
    localparam logic                   RstnEnable  = 1'b0;
    localparam logic [InstAddrBus-1:0] ResetVector = 32'h0000_0000;

    typedef enum logic {
        IfStateRun   = 1'b0,
        IfStateDslot = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_ent_t;

    function automatic logic [InstAddrBus-1:0] seq_pc(input logic [InstAddrBus-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_fifo.sv
// if_fifo: 2-entry pc+inst return queue with push, pop, flush-keeping-matching-head and count.
// Latency: one cycle from push to head. Backpressure: push is dropped when full; the owner never pushes into a full queue.
// Flush wins over push; a matching head survives the flush only if it is not popped in the same cycle.
module if_fifo
    import if_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [63:0]            push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] keep_pc_i,
    output logic [63:0]            head_o,
    output logic [1:0]             count_o
);

    fetch_ent_t ent_q [FifoDepth];
    fetch_ent_t ent_d [FifoDepth];
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            if (!pop_i && cnt_q != 2'd0 && ent_q[0].pc == keep_pc_i) begin
                cnt_d = 2'd1;
            end else begin
                cnt_d = 2'd0;
            end
        end else begin
            if (pop_i && cnt_q != 2'd0) begin
                ent_d[0] = ent_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
            if (push_i && cnt_d < 2'(FifoDepth)) begin
                ent_d[cnt_d[0]] = push_dat_i;
                cnt_d           = cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            cnt_q    <= 2'd0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = ent_q[0];
    assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage owning the PC, a 2-word return queue and the IF/ID register; IF_PERF_CNT_EN adds load counters.
// Latency: ack in cycle N appears on pc_o/inst_o in N+1 (bypass) when the queue is empty and decode is not stalled.
// Backpressure: stall_i freezes IF/ID; fetching continues until 2 words are queued, then imem_req_o drops.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_VECTOR = ResetVector
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_address_i,
    output logic                   imem_req_o,
    output logic [InstAddrBus-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [InstBus-1:0]     imem_rdata_i,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]            fetch_cnt_o,
    output logic [31:0]            bubble_cnt_o,
`endif
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    if_state_e              state_q, state_d;
    logic                   run_q;
    logic [InstAddrBus-1:0] fetch_pc_q, fetch_pc_d;
    logic [InstAddrBus-1:0] tgt_q, tgt_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstBus-1:0]     inst_q, inst_d;

    logic [63:0]            fifo_head_dat;
    fetch_ent_t             head;
    logic [1:0]             fifo_cnt;
    logic                   fifo_push, fifo_pop, fifo_flush;

    logic [InstAddrBus-1:0] dslot_pc;
    logic                   q_empty, br_acc, head_match, ack_match, xfer;

    assign head       = fifo_head_dat;
    assign q_empty    = (fifo_cnt == 2'd0);
    assign dslot_pc   = seq_pc(pc_q);
    assign br_acc     = branch_flag_i & ~stall_i & (state_q == IfStateRun);
    assign head_match = !q_empty && (head.pc == dslot_pc);

    // A redirect with queued words discards whatever would arrive now, so stop asking.
    assign imem_req_o  = run_q && (fifo_cnt != 2'(FifoDepth)) && !(br_acc && !q_empty);
    assign imem_addr_o = fetch_pc_q;
    assign xfer        = imem_req_o & imem_ack_i;
    assign ack_match   = xfer && (fetch_pc_q == dslot_pc);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        tgt_d      = tgt_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (xfer) begin
            fetch_pc_d = seq_pc(fetch_pc_q);
        end
        if (state_q == IfStateDslot && xfer) begin
            fetch_pc_d = tgt_q;
            state_d    = IfStateRun;
        end

        if (br_acc) begin
            fifo_flush = 1'b1;
            fifo_pop   = !q_empty;
            if (head_match) begin
                pc_d   = head.pc;
                inst_d = head.inst;
            end else if (ack_match) begin
                pc_d   = fetch_pc_q;
                inst_d = imem_rdata_i;
            end else begin
                pc_d   = ZeroWord;
                inst_d = ZeroWord;
            end
            if (head_match || ack_match) begin
                fetch_pc_d = branch_target_address_i;
            end else begin
                // Delay slot not yet fetched: go get it, remember where to go afterwards.
                state_d    = IfStateDslot;
                tgt_d      = branch_target_address_i;
                fetch_pc_d = dslot_pc;
            end
        end else if (!stall_i) begin
            if (!q_empty) begin
                pc_d      = head.pc;
                inst_d    = head.inst;
                fifo_pop  = 1'b1;
                fifo_push = xfer;
            end else if (xfer) begin
                pc_d   = fetch_pc_q;
                inst_d = imem_rdata_i;
            end else begin
                pc_d   = ZeroWord;
                inst_d = ZeroWord;
            end
        end else begin
            fifo_push = xfer;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            state_q    <= IfStateRun;
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_VECTOR;
            tgt_q      <= ZeroWord;
            pc_q       <= ZeroWord;
            inst_q     <= ZeroWord;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            tgt_q      <= tgt_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

    if_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i ({fetch_pc_q, imem_rdata_i}),
        .pop_i      (fifo_pop),
        .flush_i    (fifo_flush),
        .keep_pc_i  (dslot_pc),
        .head_o     (fifo_head_dat),
        .count_o    (fifo_cnt)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;
    logic        ld_real;

    assign ld_real = br_acc ? (head_match | ack_match) : (!q_empty | xfer);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else if (!stall_i) begin
            if (ld_real) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule
